// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave register file with byte-lane strobes, OKAY/SLVERR responses
// and an active-low 7-segment display of the last read's low nibble.
module axil_regfile_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic [6:0]          seg_n
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic              wr_in_range;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign ar_hs       = arvalid & arready;
  assign commit      = aw_held & w_held & ~bvalid;
  assign wr_in_range = {1'b0, awaddr_q} < DEPTH_L;
  assign rd_in_range = {1'b0, araddr} < DEPTH_L;
  assign rd_word     = rd_in_range ? mem[araddr] : '0;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Write side: AW and W are held independently, then committed together
  // while no response is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      awready <= aw_hs ? 1'b0 : (~aw_held & ~bvalid);
      wready  <= w_hs  ? 1'b0 : (~w_held & ~bvalid);
      if (aw_hs) begin
        awaddr_q <= awaddr;
        aw_held  <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
        w_held  <= 1'b1;
      end
      if (commit) begin
        if (wr_in_range) begin
          for (int k = 0; k < STRB_W; k++)
            if (wstrb_q[k]) mem[awaddr_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
        end
        bresp   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        bvalid  <= 1'b1;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read side samples memory before any same-edge commit lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      seg_n   <= 7'b0000001;
    end else begin
      arready <= ar_hs ? 1'b0 : ~rvalid;
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
        rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        seg_n  <= hex_seg(rd_word[3:0]);
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Scoreboard bench for axil_regfile_slave (DATA_W=16, DEPTH=12): directed
// corner cases followed by randomized transactions against an array model.
module tb_axil_regfile_slave;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;

  logic        clk;
  logic        reset;
  logic        awvalid, awready;
  logic [3:0]  awaddr;
  logic        wvalid, wready;
  logic [15:0] wdata;
  logic [1:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  araddr;
  logic        rvalid, rready;
  logic [15:0] rdata;
  logic [1:0]  rresp;
  logic [6:0]  seg_n;

  logic use_rand, bready_man, rready_man, bready_rnd, rready_rnd;
  assign bready = use_rand ? bready_rnd : bready_man;
  assign rready = use_rand ? rready_rnd : rready_man;

  axil_regfile_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .seg_n(seg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  r;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [15:0] exp_mem [16];
  int          checks = 0;
  int          errors = 0;

  // Segment patterns {a..g}, active-low, for hex digits 0..F.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'(i);
  endtask

  task automatic model_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
    if (a < DEPTH) begin
      for (int k = 0; k < 2; k++)
        if (s[k]) exp_mem[a][8*k +: 8] = d[8*k +: 8];
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic model_read(input logic [3:0] a);
    rexp_t e;
    e.d = (a < DEPTH) ? exp_mem[a] : 16'h0;
    e.r = (a < DEPTH) ? 2'b00 : 2'b10;
    rq.push_back(e);
  endtask

  // ch: 0 awready, 1 wready, 2 arready, 3 B handshake, 4 R handshake.
  // Returns just after the edge on which the handshake happens.
  task automatic wait_ready(input int ch);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((ch == 0 && awready) || (ch == 1 && wready) || (ch == 2 && arready) ||
          (ch == 3 && bvalid && bready) || (ch == 4 && rvalid && rready)) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL timeout ch=%0d actual=no_handshake required=handshake", ch);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s,
                          input int dly_aw, input int dly_w);
    model_write(a, d, s);
    fork
      begin
        repeat (dly_aw) @(posedge clk);
        #1 awaddr = a; awvalid = 1'b1;
        wait_ready(0);
        awvalid = 1'b0;
      end
      begin
        repeat (dly_w) @(posedge clk);
        #1 wdata = d; wstrb = s; wvalid = 1'b1;
        wait_ready(1);
        wvalid = 1'b0;
      end
    join
    wait_ready(3);
  endtask

  task automatic do_read(input logic [3:0] a, input int dly);
    model_read(a);
    repeat (dly) @(posedge clk);
    #1 araddr = a; arvalid = 1'b1;
    wait_ready(2);
    arvalid = 1'b0;
    wait_ready(4);
  endtask

  // Monitor: compares each response on the cycle before its handshake edge.
  initial begin
    rexp_t e;
    logic [1:0] eb;
    forever begin
      @(negedge clk);
      if (!reset && bvalid && bready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual=bvalid required=no_response");
        end else begin
          eb = bq.pop_front();
          check("bresp", 32'(bresp), 32'(eb));
        end
      end
      if (!reset && rvalid && rready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual=rvalid required=no_response");
        end else begin
          e = rq.pop_front();
          check("rdata", 32'(rdata), 32'(e.d));
          check("rresp", 32'(rresp), 32'(e.r));
          check("seg_n", 32'(seg_n), 32'(seg_tab[e.d[3:0]]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 bready_rnd = ($urandom_range(0, 3) != 0);
      rready_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    reset = 1'b1;
    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; arvalid = 0; araddr = 0;
    use_rand = 0; bready_man = 1; rready_man = 1; bready_rnd = 0; rready_rnd = 0;
    model_reset();
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_ready_bv_rv", 32'({wready, arready, bvalid, rvalid}), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_resp", 32'({bresp, rresp}), 0);
    check("rst_seg", 32'(seg_n), 32'(7'b0000001));
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_readies", 32'({awready, wready, arready}), 32'(3'b111));

    // Read addr 5 with arready timing.
    model_read(4'd5);
    araddr = 4'd5; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    check("rd5_arready_low", 32'(arready), 0);
    check("rd5_rvalid", 32'(rvalid), 1);
    check("rd5_seg", 32'(seg_n), 32'(7'b0100100));
    @(posedge clk); #1;
    check("rd5_rvalid_clr", 32'(rvalid), 0);
    check("rd5_arready_still_low", 32'(arready), 0);
    @(posedge clk); #1;
    check("rd5_arready_back", 32'(arready), 1);

    // AW and W in the same cycle.
    model_write(4'd3, 16'h00A7, 2'b01);
    awaddr = 4'd3; awvalid = 1; wdata = 16'h00A7; wstrb = 2'b01; wvalid = 1;
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    check("wr3_bvalid_e0", 32'(bvalid), 0);
    check("wr3_readies_low", 32'({awready, wready}), 0);
    @(posedge clk); #1;
    check("wr3_bvalid_e1", 32'(bvalid), 1);
    @(posedge clk); #1;
    check("wr3_bvalid_clr", 32'(bvalid), 0);
    do_read(4'd3, 0);

    // W first, AW three cycles later, response stalled.
    bready_man = 0;
    model_write(4'd9, 16'h005C, 2'b11);
    wdata = 16'h005C; wstrb = 2'b11; wvalid = 1;
    @(posedge clk); #1 wvalid = 0;
    check("w9_wready_low", 32'(wready), 0);
    repeat (3) @(posedge clk);
    #1 awaddr = 4'd9; awvalid = 1;
    @(posedge clk); #1 awvalid = 0;
    @(posedge clk); #1;
    check("w9_bvalid", 32'(bvalid), 1);
    awaddr = 4'd1; awvalid = 1; wdata = 16'hFFFF; wstrb = 2'b11; wvalid = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("stall_readies", 32'({awready, wready}), 0);
      check("stall_b_stable", 32'({bvalid, bresp}), 32'(3'b100));
    end
    awvalid = 0; wvalid = 0; bready_man = 1;
    wait_ready(3);
    do_read(4'd9, 1);
    do_read(4'd1, 0);

    // Strobes and out-of-range.
    do_write(4'd2, 16'hBEEF, 2'b10, 0, 1);
    do_read(4'd2, 0);
    do_write(4'd7, 16'h1234, 2'b00, 2, 0);
    do_read(4'd7, 0);
    do_write(4'd14, 16'hDEAD, 2'b11, 1, 1);
    do_read(4'd14, 0);

    // Same-edge read and commit to addr 4, then reset with bvalid pending.
    bready_man = 0;
    model_read(4'd4);
    model_write(4'd4, 16'h0033, 2'b11);
    awaddr = 4'd4; awvalid = 1; wdata = 16'h0033; wstrb = 2'b11; wvalid = 1;
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    araddr = 4'd4; arvalid = 1;
    @(posedge clk); #1 arvalid = 0;
    wait_ready(4);
    do_read(4'd4, 0);
    check("pre_rst_bvalid", 32'(bvalid), 1);
    #2 reset = 1'b1;
    #1 check("mid_rst_bvalid", 32'(bvalid), 0);
    bq.delete();
    model_reset();
    @(posedge clk); #3 reset = 1'b0;
    bready_man = 1;
    @(posedge clk); #1;
    do_read(4'd4, 0);

    // Randomized traffic with random ready backpressure.
    use_rand = 1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end
    use_rand = 0;
    repeat (10) @(posedge clk);
    #1;
    check("rq_drained", 32'(rq.size()), 0);
    check("bq_drained", 32'(bq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
